quick_mem: RTL and testbench

QUICK_MEM -- requirements
Module: quick_mem

---
 rtl/quick_pkg.sv | 22 ++
 rtl/quick_mem_array.sv | 35 +++
 rtl/quick_mem.sv | 149 ++++++++++++++
 tb/tb_quick_mem.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quick_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | quick_pkg : shared states and constants for quick_mem               |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package quick_pkg;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      RUN  = 1'b1
   } top_state_e;

   typedef enum logic [0:0] {
      WIDLE = 1'b0,
      WDATA = 1'b1
   } bus_state_e;

   localparam logic [7:0]  C_MMIO_ADDR     = 8'hFF;
   localparam int unsigned C_DEFAULT_DEPTH = 32;

endpackage
`default_nettype wire

// File: rtl/quick_mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | quick_mem_array : DEPTH x 8 storage, async read, sync write/clear   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module quick_mem_array
   import quick_pkg::*;
#(
   parameter int unsigned DEPTH = C_DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [7:0]               wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [7:0]               rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/quick_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | quick_mem : program-load memory and CPU bus bridge                  |
// | Optional memory-mapped port at 0xFF selected by QUICK_MEM_MMIO_EN   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module quick_mem
   import quick_pkg::*;
#(
   parameter int unsigned DEPTH = C_DEFAULT_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bus_ad,
   input  logic       mem_read,
   input  logic       mem_write,
   output logic [7:0] rd_data,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   input  logic       ld_done,
   output logic       cpu_rst_n,
   output logic       err,
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int unsigned     AW     = $clog2(DEPTH);
   localparam logic [AW-1:0]   C_LAST = AW'(DEPTH - 1);

   top_state_e    state_q;
   bus_state_e    bus_q;
   logic [AW-1:0] ld_ptr_q;
   logic [7:0]    wr_addr_q;
   logic          err_q;
   logic [7:0]    io_out_q;
   logic          cpu_rst_n_q;
   logic          ld_ready_q;

   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [7:0]    w_wdata;
   logic [7:0]    w_arr_rdata;
   logic          w_mmio_wr_hit;
   logic          w_mmio_rd_hit;

`ifdef QUICK_MEM_MMIO_EN
   // Only the bus path in RUN sees the port; LOAD always targets storage.
   assign w_mmio_wr_hit = (wr_addr_q == C_MMIO_ADDR);
   assign w_mmio_rd_hit = (bus_ad == C_MMIO_ADDR);
`else
   logic unused_mmio;
   assign w_mmio_wr_hit = 1'b0;
   assign w_mmio_rd_hit = 1'b0;
   assign unused_mmio   = ^{io_in, wr_addr_q};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         bus_q       <= WIDLE;
         ld_ptr_q    <= '0;
         wr_addr_q   <= 8'h00;
         err_q       <= 1'b0;
         io_out_q    <= 8'h00;
         cpu_rst_n_q <= 1'b0;
         ld_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            LOAD: begin
               if (ld_valid) begin
                  ld_ptr_q <= ld_ptr_q + 1'b1;
               end
               if (ld_done || (ld_valid && (ld_ptr_q == C_LAST))) begin
                  state_q     <= RUN;
                  cpu_rst_n_q <= 1'b1;
                  ld_ready_q  <= 1'b0;
               end
            end
            RUN: begin
               case (bus_q)
                  WIDLE: begin
                     if (mem_write) begin
                        wr_addr_q <= bus_ad;
                        bus_q     <= WDATA;
                        if (mem_read) begin
                           err_q <= 1'b1;
                        end
                     end
                  end
                  WDATA: begin
                     bus_q <= WIDLE;
                     if (mem_read || mem_write) begin
                        err_q <= 1'b1;
                     end
                     if (w_mmio_wr_hit) begin
                        io_out_q <= bus_ad;
                     end
                  end
                  default: bus_q <= WIDLE;
               endcase
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = 8'h00;
      if (state_q == LOAD) begin
         w_we    = ld_valid;
         w_waddr = ld_ptr_q;
         w_wdata = ld_data;
      end else if (bus_q == WDATA) begin
         w_we    = !w_mmio_wr_hit;
         w_waddr = wr_addr_q[AW-1:0];
         w_wdata = bus_ad;
      end
   end

   quick_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .clr_i   (!rst_n),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (w_wdata),
      .raddr_i (bus_ad[AW-1:0]),
      .rdata_o (w_arr_rdata)
   );

   // A combined read+write strobe is a write, so the read path stays quiet.
   always_comb begin
      rd_data = 8'h00;
      if ((state_q == RUN) && (bus_q == WIDLE) && mem_read && !mem_write) begin
         rd_data = w_mmio_rd_hit ? io_in : w_arr_rdata;
      end
   end

   assign ld_ready  = ld_ready_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign err       = err_q;
   assign io_out    = io_out_q;

endmodule
`default_nettype wire

// File: tb/tb_quick_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_quick_mem : scoreboard testbench for quick_mem                   |
// | Honours QUICK_MEM_MMIO_EN for the memory-mapped port scenario       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_quick_mem;

   localparam int DEPTH = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] bus_ad = 8'h00;
   logic       mem_read = 1'b0;
   logic       mem_write = 1'b0;
   logic [7:0] rd_data;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic       ld_ready;
   logic       ld_done = 1'b0;
   logic       cpu_rst_n;
   logic       err;
   logic [7:0] io_in = 8'h00;
   logic [7:0] io_out;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] model [DEPTH];
   logic [7:0] io_m = 8'h00;
   logic [7:0] sb_q [$];
   logic [7:0] exp_v;

   quick_mem #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_ad    (bus_ad),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .rd_data   (rd_data),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .ld_done   (ld_done),
      .cpu_rst_n (cpu_rst_n),
      .err       (err),
      .io_in     (io_in),
      .io_out    (io_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_read(input logic [7:0] a);
`ifdef QUICK_MEM_MMIO_EN
      if (a == 8'hFF) return io_in;
`endif
      return model[int'(a) % DEPTH];
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      ld_valid = 1'b0; ld_done = 1'b0; bus_ad = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      foreach (model[i]) model[i] = 8'h00;
      io_m = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mem_read = 1'b0; mem_write = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
      end
   endtask

   task automatic enter_run();
      @(negedge clk);
      ld_valid = 1'b0; ld_done = 1'b1;
      @(negedge clk);
      ld_done = 1'b0;
   endtask

   // Drives one read cycle and queues what the CPU must see; in_run=0 expects 0.
   task automatic drive_read(input logic [7:0] a, input logic in_run);
      @(negedge clk);
      bus_ad = a; mem_read = 1'b1; mem_write = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
      sb_q.push_back(in_run ? exp_read(a) : 8'h00);
      #1;
   endtask

   task automatic drive_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus_ad = a; mem_write = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      bus_ad = d; mem_write = 1'b0;
`ifdef QUICK_MEM_MMIO_EN
      if (a == 8'hFF) io_m = d;
      else model[int'(a) % DEPTH] = d;
`else
      model[int'(a) % DEPTH] = d;
`endif
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++; if (ld_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ld_ready got=%b exp=1", ld_ready); end
      n_tests++; if (cpu_rst_n !== 1'b0)  begin n_fail++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
      n_tests++; if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
      n_tests++; if (io_out !== 8'h00)    begin n_fail++; $display("FAIL rst_io_out got=%h exp=00", io_out); end
      drive_read(8'h00, 1'b0);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v)   begin n_fail++; $display("FAIL rst_rd_data got=%h exp=%h", rd_data, exp_v); end
   endtask

   task automatic test_load();
      logic [7:0] bytes [3];
      bytes[0] = 8'h0D; bytes[1] = 8'h33; bytes[2] = 8'h1D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_read = 1'b0; ld_valid = 1'b1; ld_data = bytes[i];
         model[i] = bytes[i];
         #1;
         n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready[%0d] got=%b exp=1", i, ld_ready); end
      end
      drive_read(8'h01, 1'b0);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL load_strobe_ignored got=%h exp=%h", rd_data, exp_v); end
      @(negedge clk);
      mem_read = 1'b0; ld_valid = 1'b0; ld_done = 1'b1;
      #1;
      n_tests++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL load_cpu_rst_early got=%b exp=0", cpu_rst_n); end
      @(negedge clk);
      ld_done = 1'b0;
      n_tests++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL load_cpu_rst_rise got=%b exp=1", cpu_rst_n); end
      n_tests++; if (ld_ready !== 1'b0)  begin n_fail++; $display("FAIL load_ready_drop got=%b exp=0", ld_ready); end
      // Loader traffic in RUN must not reach storage.
      ld_valid = 1'b1; ld_data = 8'hEE;
      @(negedge clk);
      ld_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_read(8'(i), 1'b1);
         exp_v = sb_q.pop_front();
         n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL load_entry[%0d] got=%h exp=%h", i, rd_data, exp_v); end
      end
      drive_read(8'h01, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL read_0x01 got=%h exp=33", rd_data); end
      @(negedge clk);
      mem_read = 1'b0;
      sb_q.push_back(8'h00);
      #1;
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL read_idle got=%h exp=%h", rd_data, exp_v); end
   endtask

   task automatic test_write();
      drive_write(8'h05, 8'hA7);
      drive_read(8'h05, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL write_rdback got=%h exp=%h", rd_data, exp_v); end
      drive_write(8'h45, 8'h3E);
      drive_write(8'h0A, 8'hC1);
      drive_write(8'h0B, 8'h72);
      foreach (sb_q[i]) sb_q.delete(i);
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a, d;
         a = 8'($urandom_range(0, 254));
         d = 8'($urandom);
         drive_write(a, d);
      end
      for (int i = 0; i < 12; i++) begin
         drive_read(8'(i), 1'b1);
         exp_v = sb_q.pop_front();
         n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL write_entry[%0d] got=%h exp=%h", i, rd_data, exp_v); end
      end
      idle(1);
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err_clean got=%b exp=0", err); end
   endtask

   task automatic test_errors();
      @(negedge clk);
      bus_ad = 8'h06; mem_read = 1'b1; mem_write = 1'b1;
      sb_q.push_back(8'h00);
      #1;
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL both_rd_data got=%h exp=%h", rd_data, exp_v); end
      @(negedge clk);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL both_err got=%b exp=1", err); end
      bus_ad = 8'h11; mem_read = 1'b0; mem_write = 1'b1;
      model[6] = 8'h11;
      idle(3);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
      drive_read(8'h06, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL both_as_write got=%h exp=%h", rd_data, exp_v); end

      apply_reset();
      enter_run();
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", err); end
      @(negedge clk);
      bus_ad = 8'h07; mem_write = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      bus_ad = 8'h44; mem_write = 1'b0; mem_read = 1'b1;
      model[7] = 8'h44;
      sb_q.push_back(8'h00);
      #1;
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL wdata_rd_data got=%h exp=%h", rd_data, exp_v); end
      idle(1);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wdata_strobe_err got=%b exp=1", err); end
      drive_read(8'h07, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL wdata_written got=%h exp=%h", rd_data, exp_v); end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      bus_ad = 8'h03; mem_write = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      bus_ad = 8'h99; mem_write = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      foreach (model[i]) model[i] = 8'h00;
      io_m = 8'h00;
      n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL midrst_err got=%b exp=0", err); end
      n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ld_ready got=%b exp=1", ld_ready); end
      enter_run();
      for (int i = 2; i < 8; i++) begin
         drive_read(8'(i), 1'b1);
         exp_v = sb_q.pop_front();
         n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL midrst_entry[%0d] got=%h exp=%h", i, rd_data, exp_v); end
      end
   endtask

   task automatic test_auto_load();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 10) begin
            @(negedge clk);
            ld_valid = 1'b0;
         end
         @(negedge clk);
         n_tests++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL auto_early_run[%0d] got=%b exp=0", i, cpu_rst_n); end
         ld_valid = 1'b1; ld_data = 8'(i * 37 + 11);
         model[i] = 8'(i * 37 + 11);
      end
      @(negedge clk);
      ld_valid = 1'b0;
      n_tests++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL auto_run got=%b exp=1", cpu_rst_n); end
      n_tests++; if (ld_ready !== 1'b0)  begin n_fail++; $display("FAIL auto_ld_ready got=%b exp=0", ld_ready); end
      drive_read(8'h20, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL auto_alias_0x20 got=%h exp=%h", rd_data, exp_v); end
      drive_read(8'h1F, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL auto_last got=%h exp=%h", rd_data, exp_v); end
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 254));
         drive_read(a, 1'b1);
         exp_v = sb_q.pop_front();
         n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL auto_rand addr=%h got=%h exp=%h", a, rd_data, exp_v); end
      end
   endtask

   task automatic test_mmio();
      io_in = 8'h3C;
      drive_write(8'hFF, 8'h5A);
      idle(1);
      n_tests++; if (io_out !== io_m) begin n_fail++; $display("FAIL mmio_io_out got=%h exp=%h", io_out, io_m); end
      drive_read(8'hFF, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL mmio_read_ff got=%h exp=%h", rd_data, exp_v); end
      drive_read(8'h1F, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL mmio_entry31 got=%h exp=%h", rd_data, exp_v); end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_load();
      test_write();
      test_errors();
      test_reset_mid_write();
      test_auto_load();
      test_mmio();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
